// File: rtl/wm_pkg.sv
// Shared types and constants for the wake-mission step path.
// The count width is shared with the step counter.
package wm_pkg;

  localparam int WM_CNT_W          = 4;
  localparam int WM_TARGET_DEFAULT = 9;

  typedef enum logic [2:0] {
    WM_IDLE         = 3'd0,
    WM_CLEAR        = 3'd1,
    WM_WAIT_PRESS   = 3'd2,
    WM_ISSUE        = 3'd3,
    WM_REARM        = 3'd4,
    WM_WAIT_RELEASE = 3'd5,
    WM_DONE         = 3'd6
  } wm_state_t;

endpackage

// File: rtl/wm_idle_timer.sv
// Idle-cycle counter; expired is high on the last idle cycle.
// Only instantiated when WM_TIMEOUT_EN is defined.
module wm_idle_timer
  import wm_pkg::*;
#(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wm_step_issuer.sv
// Turns button presses into CE/count_stop step requests and reports done.
// Optional idle timeout enabled by WM_TIMEOUT_EN.
module wm_step_issuer
  import wm_pkg::*;
#(
  parameter int TARGET         = WM_TARGET_DEFAULT,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic                btn,
  input  logic                thresh,
  output logic                CE,
  output logic                count_stop,
  output logic                cnt_clr,
  output logic                done,
  output logic [WM_CNT_W-1:0] remaining,
  output logic                timeout_pulse
);

  localparam logic [WM_CNT_W-1:0] TGT = WM_CNT_W'(TARGET);

  wm_state_t           state_q, state_d;
  logic [WM_CNT_W-1:0] shadow_q, shadow_d;
  logic [WM_CNT_W-1:0] remaining_q, remaining_d;
  logic                ce_q, ce_d;
  logic                cs_q, cs_d;
  logic                clr_q, clr_d;
  logic                done_q, done_d;
  logic                tp_q, tp_d;
  logic                expired;

`ifdef WM_TIMEOUT_EN
  wm_idle_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q != WM_WAIT_PRESS),
    .en     (state_q == WM_WAIT_PRESS),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tp_d    = 1'b0;
    unique case (state_q)
      WM_IDLE:         if (arm) state_d = WM_CLEAR;
      WM_CLEAR:        state_d = WM_WAIT_PRESS;
      WM_WAIT_PRESS: begin
        if (thresh) begin
          state_d = WM_DONE;
        end else if (btn) begin
          state_d = WM_ISSUE;
        end else if (expired) begin
          state_d = WM_CLEAR;
          tp_d    = 1'b1;
        end
      end
      WM_ISSUE:        state_d = WM_REARM;
      WM_REARM:        state_d = WM_WAIT_RELEASE;
      WM_WAIT_RELEASE: begin
        if (thresh) begin
          state_d = WM_DONE;
        end else if (!btn) begin
          state_d = WM_WAIT_PRESS;
        end
      end
      WM_DONE:         state_d = WM_DONE;
      default:         state_d = WM_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle press or timeout
    if (!arm && state_q != WM_IDLE) begin
      state_d = WM_IDLE;
      tp_d    = 1'b0;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (state_q == WM_CLEAR) begin
      shadow_d = '0;
    end else if (state_q == WM_ISSUE && shadow_q != TGT) begin
      shadow_d = shadow_q + 1'b1;
    end
    remaining_d = TGT - shadow_d;
    ce_d        = (state_d == WM_ISSUE);
    cs_d        = (state_d == WM_REARM);
    clr_d       = (state_d == WM_CLEAR);
    done_d      = (state_d == WM_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WM_IDLE;
      shadow_q    <= '0;
      remaining_q <= TGT;
      ce_q        <= 1'b0;
      cs_q        <= 1'b0;
      clr_q       <= 1'b0;
      done_q      <= 1'b0;
      tp_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      remaining_q <= remaining_d;
      ce_q        <= ce_d;
      cs_q        <= cs_d;
      clr_q       <= clr_d;
      done_q      <= done_d;
      tp_q        <= tp_d;
    end
  end

  assign CE            = ce_q;
  assign count_stop    = cs_q;
  assign cnt_clr       = clr_q;
  assign done          = done_q;
  assign remaining     = remaining_q;
  assign timeout_pulse = tp_q;

endmodule

// File: tb/tb_wm_step_issuer.sv
// Directed bench for wm_step_issuer with a behavioural step counter.
// Timeout section active when WM_TIMEOUT_EN is defined.
module tb_wm_step_issuer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arm = 1'b0;
  logic       btn = 1'b0;
  logic       thresh;
  logic       CE, count_stop, cnt_clr, done, timeout_pulse;
  logic [3:0] remaining;

  int errs = 0;
  int checks = 0;
  int ce_cnt = 0;
  int cs_cnt = 0;
  int cnt_m = 0;
  logic thr_m = 1'b0;

  wm_step_issuer #(
    .TARGET        (9),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .btn          (btn),
    .thresh       (thresh),
    .CE           (CE),
    .count_stop   (count_stop),
    .cnt_clr      (cnt_clr),
    .done         (done),
    .remaining    (remaining),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Step counter: count lands at end of ISSUE, Thresh one cycle later
  always @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_m <= 0;
      thr_m <= 1'b0;
    end else begin
      if (CE && cnt_m < 9) cnt_m <= cnt_m + 1;
      thr_m <= (cnt_m >= 9);
    end
  end
  assign thresh = thr_m;

  always @(posedge clk) begin
    if (CE) ce_cnt <= ce_cnt + 1;
    if (count_stop) cs_cnt <= cs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press();
    btn = 1'b1;
    tick();
    btn = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    int waited;
    int ce0;
    int tp_n;
    int clr_n;
    int tp_at;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ce", CE, 0);
    chk("rst_cs", count_stop, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_done", done, 0);
    chk("rst_tp", timeout_pulse, 0);
    chk("rst_rem", remaining, 9);

    arm = 1'b1;
    chk("arm_clr_pre", cnt_clr, 0);
    tick();
    chk("arm_clr", cnt_clr, 1);
    tick();
    chk("arm_clr_one", cnt_clr, 0);
    chk("arm_rem", remaining, 9);

    // Single press held for 20 cycles
    btn = 1'b1;
    tick();
    chk("hold_ce", CE, 1);
    chk("hold_cs0", count_stop, 0);
    tick();
    chk("hold_ce0", CE, 0);
    chk("hold_cs", count_stop, 1);
    chk("hold_rem", remaining, 8);
    repeat (18) tick();
    chk("hold_no_ce", CE, 0);
    btn = 1'b0;
    tick();
    tick();
    chk("hold_ce_cnt", ce_cnt, 1);
    chk("hold_cs_cnt", cs_cnt, 1);

    for (int i = 2; i <= 8; i++) begin
      press();
      chk("press_rem", remaining, 9 - i);
    end

    // Ninth press reaches the terminal count
    btn = 1'b1;
    tick();
    chk("p9_ce", CE, 1);
    btn = 1'b0;
    waited = 0;
    while (!done && waited < 3) begin
      tick();
      waited++;
    end
    chk("p9_done", done, 1);
    chk("p9_rem", remaining, 0);

    btn = 1'b1;
    repeat (4) tick();
    btn = 1'b0;
    repeat (2) tick();
    chk("p10_no_ce", ce_cnt, 9);
    chk("p10_done", done, 1);

    arm = 1'b0;
    tick();
    chk("disarm_done", done, 0);
    chk("disarm_rem", remaining, 0);
    arm = 1'b1;
    tick();
    chk("rearm_clr", cnt_clr, 1);
    tick();
    chk("rearm_rem", remaining, 9);

    // Abort after four presses
    repeat (4) press();
    chk("abort_pre_rem", remaining, 5);
    arm = 1'b0;
    tick();
    chk("abort_done", done, 0);
    chk("abort_ce", CE, 0);
    chk("abort_rem", remaining, 5);
    arm = 1'b1;
    tick();
    chk("abort_clr", cnt_clr, 1);
    tick();
    chk("abort_rem9", remaining, 9);

    // Press coincident with disarm
    ce0 = ce_cnt;
    arm = 1'b0;
    btn = 1'b1;
    tick();
    chk("simul_ce_a", CE, 0);
    tick();
    chk("simul_ce_b", CE, 0);
    btn = 1'b0;
    tick();
    chk("simul_cnt", ce_cnt, ce0);

    // Button already high on the first WAIT_PRESS cycle
    arm = 1'b1;
    tick();
    btn = 1'b1;
    tick();
    tick();
    chk("entry_ce", CE, 1);
    btn = 1'b0;
    repeat (3) tick();
    chk("entry_rem", remaining, 8);

    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    tick();

`ifdef WM_TIMEOUT_EN
    repeat (3) press();
    chk("to_pre_rem", remaining, 6);
    tp_n = 0;
    clr_n = 0;
    tp_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (timeout_pulse) begin
        tp_n++;
        tp_at = i;
      end
      if (cnt_clr) clr_n++;
    end
    chk("to_pulses", tp_n, 1);
    chk("to_when", tp_at, 16);
    chk("to_clr", clr_n, 1);
    chk("to_rem", remaining, 9);
`else
    tp_n = 0;
    clr_n = 0;
    tp_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (timeout_pulse) tp_n++;
      if (cnt_clr) clr_n++;
    end
    chk("no_to_pulse", tp_n, 0);
    chk("no_to_clr", clr_n, tp_at);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wm_step_issuer.md
# wm_step_issuer

Initiator side of the wake-mission step-counter handshake: it turns user button presses into single-increment requests (`CE`, then `count_stop`) for the wake-mission digit counter, watches that counter's `Thresh`, and reports mission completion to the alarm controller. It sits between the debounced button path and the step counter and owns the counter's clear. It also keeps a shadow count so the display can show presses remaining, independent of counter readback.

## Interface
- `TARGET`, 9: count at which the step counter raises `Thresh`. Must match the counter's terminal value.
- `TIMEOUT_CYCLES`, 500_000_000: idle cycles in WAIT_PRESS before progress is discarded. Used only with `WM_TIMEOUT_EN`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  level; high while the alarm is ringing and a mission is required.
- `btn`  in  1  debounced button level, synchronous to `clk`.
- `thresh`  in  1  `Thresh` from the step counter.
- `CE`  out  1  increment request to the counter; registered.
- `count_stop`  out  1  re-arm strobe to the counter; registered.
- `cnt_clr`  out  1  one-cycle clear to the counter's `reset`; registered.
- `done`  out  1  mission complete; held until `arm` falls.
- `remaining`  out  4  `TARGET` minus the shadow count; registered.
- `timeout_pulse`  out  1  one-cycle pulse when progress is discarded. Tied 0 without `WM_TIMEOUT_EN`.

## Operation
- States: IDLE, CLEAR, WAIT_PRESS, ISSUE, REARM, WAIT_RELEASE, DONE.
- **IDLE:** all strobes 0. `arm`=1 → CLEAR.
- **CLEAR:** `cnt_clr`=1 for one cycle; shadow count ← 0. → WAIT_PRESS.
- **WAIT_PRESS:**
  - `thresh`=1 → DONE. This has priority over `btn`.
  - Otherwise `btn`=1 → ISSUE.
- **ISSUE:** `CE`=1 and `count_stop`=0 for exactly one cycle; shadow count +1, saturating at `TARGET`. → REARM.
- **REARM:** `CE`=0 and `count_stop`=1 for exactly one cycle. → WAIT_RELEASE.
- **WAIT_RELEASE:**
  - `thresh`=1 → DONE.
  - `btn`=0 → WAIT_PRESS.
  - A held button therefore produces exactly one increment.
- **DONE:** `done`=1. `arm`=0 → IDLE.
- **Abort:** `arm`=0 in any non-IDLE state → IDLE next cycle. All strobes drop and no clear is issued; the next arm performs the clear.
- **Remaining count:** `remaining` = `TARGET` − shadow, a 4-bit unsigned value. It never underflows, because the shadow count saturates. It is not reloaded on abort; it reloads to `TARGET` in CLEAR.
- **Simultaneous events:**
  - `btn` rising in the same cycle the state enters WAIT_PRESS is accepted.
  - `arm` falling and `btn` rising together → abort wins.

## Timing
- Reset values:
  - state IDLE
  - `CE`=0, `count_stop`=0, `cnt_clr`=0, `done`=0, `timeout_pulse`=0
  - `remaining`=`TARGET`
- Latency from `btn` rising (sampled in WAIT_PRESS at edge n) to `CE`=1 is 1 cycle, i.e. cycle n+1.
- `count_stop` follows in cycle n+2. The minimum press-to-press spacing is 4 cycles.
- Counter response: the count updates at the end of the ISSUE cycle, and `thresh` rises 2 cycles after ISSUE. The block therefore sees it in WAIT_RELEASE or WAIT_PRESS. `done` asserts 1 cycle after `thresh` is sampled in either state.
- `cnt_clr` asserts 1 cycle after `arm` is sampled high in IDLE.
- Reset mid-mission: the next edge forces IDLE with all outputs at reset values. The counter is not cleared until the next arm.

## Configuration
- Macro: `WM_TIMEOUT_EN`.
- **Defined:**
  - An idle counter runs only in WAIT_PRESS and clears on leaving it.
  - When it reaches `TIMEOUT_CYCLES`−1, the block pulses `timeout_pulse` for one cycle and goes → CLEAR, discarding progress.
  - Timeout has lower priority than `thresh` and `btn` in the same cycle.
- **Undefined:** no idle counter exists; `timeout_pulse` is constant 0 and WAIT_PRESS waits indefinitely.

## Structure
- Shared package `wm_pkg` holds:
  - the state enum `wm_state_t`
  - `WM_TARGET_DEFAULT` = 9
  - the 4-bit count width constant, shared with the step counter
- Sub-module `wm_idle_timer` contains the timeout counter with `clr` and `en` inputs and an `expired` output. It is instantiated only under `WM_TIMEOUT_EN`.

## Test plan
- **Reset with `arm`=0:** all outputs are 0 and `remaining`=9. Raising `arm` gives `cnt_clr`=1 exactly 1 cycle later, for 1 cycle.
- **One press held 20 cycles:** exactly one `CE` pulse, followed next cycle by one `count_stop` pulse; `remaining` goes 9→8.
- **Nine separate presses with a behavioural counter model:**
  - `remaining` reaches 0.
  - `done`=1 within 3 cycles of the 9th `CE`.
  - A tenth press produces no `CE`.
- **Abort:** drop `arm` after 4 presses → IDLE, `done`=0. Re-arm gives `cnt_clr` and `remaining`=9.
- **Simultaneous:** `btn` rising in the same cycle `arm` falls → no `CE`.
- **`WM_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16:** after 3 presses, idle for 16 cycles → one `timeout_pulse`, then `cnt_clr`, then `remaining`=9.
